serial_uart_bridge: RTL and testbench

//  Buffered UART endpoint directly downstream of data_memory's serial port: consumes serial_out/serial_wren_out, produces serial_in/serial_valid_in/serial_ready_in.

---
 rtl/serial_uart_bridge_if.sv | 37 +++
 rtl/serial_uart_bridge.sv | 271 +++++++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_bridge_if.sv
// serial_uart_bridge_if: processor-side bus of the buffered UART bridge.
// slave is the bridge side, master is the datapath side.
interface serial_uart_bridge_if;
  logic [7:0] tx_data_in;
  logic       tx_wren_in;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_rden_in;
  logic       err_clr_in;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  modport slave (
    input  tx_data_in,
    input  tx_wren_in,
    output tx_ready_out,
    output rx_data_out,
    output rx_valid_out,
    input  rx_rden_in,
    input  err_clr_in,
    output rx_overrun_out,
    output rx_frame_err_out
  );

  modport master (
    output tx_data_in,
    output tx_wren_in,
    input  tx_ready_out,
    input  rx_data_out,
    input  rx_valid_out,
    output rx_rden_in,
    output err_clr_in,
    input  rx_overrun_out,
    input  rx_frame_err_out
  );
endinterface

// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge: FIFO-buffered UART endpoint for the data_memory serial port.
// Define SERIAL_PARITY_EN for 8E1 frames (even parity); default is 8N1.
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic clock,
  input  logic reset,
  serial_uart_bridge_if.slave bus,
  output logic uart_txd_out,
  input  logic uart_rxd_in
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [AW:0]   P_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   P_MSB  = {1'b1, {AW{1'b0}}};

`ifdef SERIAL_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
  } uart_state_t;
`endif

  // TX FIFO
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr;
  logic [AW:0] tx_rd;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_push;
  logic        tx_pop;
  logic [7:0]  tx_head;

  uart_state_t tx_state;
  logic [TW-1:0] tx_timer;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;
`ifdef SERIAL_PARITY_EN
  logic        tx_par;
`endif

  assign tx_empty = tx_wr == tx_rd;
  assign tx_full  = (tx_wr ^ tx_rd) == P_MSB;
  assign tx_push  = bus.tx_wren_in && !tx_full;
  assign tx_pop   = (tx_state == ST_IDLE) && !tx_empty;
  assign tx_head  = tx_mem[tx_rd[AW-1:0]];
  assign tx_tick  = tx_timer == T_LAST;
  assign bus.tx_ready_out = !tx_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + P_ONE;
      if (tx_pop)  tx_rd <= tx_rd + P_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.tx_data_in;
  end

  // txd follows the state one cycle late, which gives the 2-edge start latency
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state     <= ST_IDLE;
      tx_timer     <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      uart_txd_out <= 1'b1;
`ifdef SERIAL_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      tx_timer <= tx_tick ? '0 : tx_timer + T_ONE;
      unique case (tx_state)
        ST_IDLE: begin
          uart_txd_out <= 1'b1;
          tx_timer     <= '0;
          if (!tx_empty) begin
            tx_shift <= tx_head;
`ifdef SERIAL_PARITY_EN
            tx_par   <= ^tx_head;
`endif
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          uart_txd_out <= 1'b0;
          if (tx_tick) begin
            tx_bit   <= '0;
            tx_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          uart_txd_out <= tx_shift[0];
          if (tx_tick) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
              tx_state <= ST_PAR;
`else
              tx_state <= ST_STOP;
`endif
            end
          end
        end
`ifdef SERIAL_PARITY_EN
        ST_PAR: begin
          uart_txd_out <= tx_par;
          if (tx_tick) tx_state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          uart_txd_out <= 1'b1;
          if (tx_tick) tx_state <= ST_IDLE;
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // RX synchroniser and FSM
  logic rx_s1;
  logic rx_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rxd_in;
      rx_s2 <= rx_s1;
    end
  end

  uart_state_t rx_state;
  logic [TW-1:0] rx_timer;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_done;
  logic        rx_good;
  logic        rx_push;
  logic        rx_ferr_ev;
`ifdef SERIAL_PARITY_EN
  logic        rx_par;
`endif

  assign rx_tick = rx_timer == T_LAST;
  assign rx_done = (rx_state == ST_STOP) && rx_tick;
`ifdef SERIAL_PARITY_EN
  assign rx_good = rx_s2 && !(^rx_shift ^ rx_par);
`else
  assign rx_good = rx_s2;
`endif
  assign rx_push    = rx_done && rx_good;
  assign rx_ferr_ev = rx_done && !rx_good;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_timer <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef SERIAL_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_timer <= rx_tick ? '0 : rx_timer + T_ONE;
      unique case (rx_state)
        ST_IDLE: begin
          rx_timer <= '0;
          if (!rx_s2) rx_state <= ST_START;
        end
        ST_START: begin
          if (rx_timer == T_HALF) begin
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
              rx_state <= ST_PAR;
`else
              rx_state <= ST_STOP;
`endif
            end
          end
        end
`ifdef SERIAL_PARITY_EN
        ST_PAR: begin
          if (rx_tick) begin
            rx_par   <= rx_s2;
            rx_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (rx_tick) rx_state <= ST_IDLE;
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // RX FIFO: a pop in the same cycle frees room for a push into a full FIFO
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr;
  logic [AW:0] rx_rd;
  logic        rx_full;
  logic        rx_empty;
  logic        rx_pop;
  logic        rx_wen;
  logic        rx_ovr_ev;

  assign rx_empty  = rx_wr == rx_rd;
  assign rx_full   = (rx_wr ^ rx_rd) == P_MSB;
  assign rx_pop    = bus.rx_rden_in && !rx_empty;
  assign rx_wen    = rx_push && (!rx_full || rx_pop);
  assign rx_ovr_ev = rx_push && rx_full && !rx_pop;

  assign bus.rx_valid_out = !rx_empty;
  assign bus.rx_data_out  = rx_empty ? 8'h00 : rx_mem[rx_rd[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_wen) rx_wr <= rx_wr + P_ONE;
      if (rx_pop) rx_rd <= rx_rd + P_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_wen) rx_mem[rx_wr[AW-1:0]] <= rx_shift;
  end

  // sticky flags; a new error wins over a simultaneous clear
  logic rx_ovr_q;
  logic rx_ferr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      rx_ovr_q  <= (rx_ovr_q && !bus.err_clr_in) || rx_ovr_ev;
      rx_ferr_q <= (rx_ferr_q && !bus.err_clr_in) || rx_ferr_ev;
    end
  end

  assign bus.rx_overrun_out   = rx_ovr_q;
  assign bus.rx_frame_err_out = rx_ferr_q;
endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb_serial_uart_bridge: directed bench for serial_uart_bridge.
// Runs with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_serial_uart_bridge;
  localparam int C = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_rxd_in = 1'b1;
  logic uart_txd_out;
  logic [7:0] got;
  logic [7:0] pat;
  int checks = 0;
  int failures = 0;
  int lows;
`ifdef SERIAL_PARITY_EN
  logic par_flip = 1'b0;
  logic tx_par_seen;
`endif

  serial_uart_bridge_if bus();

  serial_uart_bridge #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .uart_txd_out(uart_txd_out),
    .uart_rxd_in(uart_rxd_in)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    @(posedge clock);
    #1;
    uart_rxd_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      uart_rxd_in = b[i];
      tick(C);
    end
`ifdef SERIAL_PARITY_EN
    uart_rxd_in = ^b ^ par_flip;
    tick(C);
`endif
    uart_rxd_in = stop;
    tick(C);
    uart_rxd_in = 1'b1;
  endtask

  task automatic tx_get(output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    while (uart_txd_out === 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("tx_start_seen", uart_txd_out, 0);
    repeat (5) @(negedge clock);
    b[0] = uart_txd_out;
    for (int i = 1; i < 8; i++) begin
      repeat (C) @(negedge clock);
      b[i] = uart_txd_out;
    end
`ifdef SERIAL_PARITY_EN
    repeat (C) @(negedge clock);
    tx_par_seen = uart_txd_out;
`endif
    repeat (C) @(negedge clock);
    check("tx_stop", uart_txd_out, 1);
  endtask

  task automatic rd_pulse();
    bus.rx_rden_in = 1'b1;
    tick(1);
    bus.rx_rden_in = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.err_clr_in = 1'b1;
    tick(1);
    bus.err_clr_in = 1'b0;
  endtask

  task automatic count_lows(input int n);
    lows = 0;
    repeat (n) begin
      @(negedge clock);
      if (uart_txd_out !== 1'b1) lows++;
    end
  endtask

  initial begin
    bus.tx_data_in = '0;
    bus.tx_wren_in = 1'b0;
    bus.rx_rden_in = 1'b0;
    bus.err_clr_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_ready", bus.tx_ready_out, 1);
    check("rst_valid", bus.rx_valid_out, 0);
    check("rst_data", bus.rx_data_out, 0);
    check("rst_txd", uart_txd_out, 1);
    check("rst_ovr", bus.rx_overrun_out, 0);
    check("rst_ferr", bus.rx_frame_err_out, 0);

    // single TX byte, exact timing
    pat = 8'b1010_0101;
    bus.tx_data_in = 8'hA5;
    bus.tx_wren_in = 1'b1;
    tick(1);
    bus.tx_wren_in = 1'b0;
    check("t1_txd_e0", uart_txd_out, 1);
    tick(1);
    check("t1_txd_e1", uart_txd_out, 1);
    tick(1);
    check("t1_start", uart_txd_out, 0);
    for (int i = 0; i < 8; i++) begin
      tick(C);
      check("t1_bit", uart_txd_out, pat[i]);
      check("t1_ready", bus.tx_ready_out, 1);
    end
`ifdef SERIAL_PARITY_EN
    tick(C);
    check("t1_par", uart_txd_out, 0);
`endif
    tick(C);
    check("t1_stop", uart_txd_out, 1);
    tick(10);

    // TX full
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          bus.tx_data_in = 8'(i);
          bus.tx_wren_in = 1'b1;
          tick(1);
          check("t2_ready", bus.tx_ready_out, (i < 5) ? 1 : 0);
        end
        bus.tx_wren_in = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          tx_get(got);
          check("t2_byte", got, k + 1);
        end
      end
    join
    count_lows(40);
    check("t2_no_extra", lows, 0);
    check("t2_ready_end", bus.tx_ready_out, 1);

    // RX path
    rx_send(8'h3C, 1'b1);
    tick(2);
    check("t3_valid", bus.rx_valid_out, 1);
    check("t3_data", bus.rx_data_out, 8'h3C);
    rd_pulse();
    check("t3_empty", bus.rx_valid_out, 0);
    check("t3_data0", bus.rx_data_out, 0);

    // overrun
    for (int i = 0; i < 5; i++) begin
      rx_send(8'(8'h10 + i), 1'b1);
      if (i == 3) begin
        tick(2);
        check("t4_no_ovr_full", bus.rx_overrun_out, 0);
      end
    end
    tick(2);
    check("t4_ovr", bus.rx_overrun_out, 1);
    check("t4_ferr", bus.rx_frame_err_out, 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_valid", bus.rx_valid_out, 1);
      check("t4_data", bus.rx_data_out, 16 + i);
      rd_pulse();
    end
    check("t4_drained", bus.rx_valid_out, 0);
    check("t4_ovr_held", bus.rx_overrun_out, 1);
    clr_pulse();
    check("t4_ovr_clr", bus.rx_overrun_out, 0);

    // push into full FIFO with a pop on the same edge
    for (int i = 0; i < 4; i++) rx_send(8'(8'h20 + i), 1'b1);
    rx_send(8'h24, 1'b1);
    bus.rx_rden_in = 1'b1;
    tick(1);
    bus.rx_rden_in = 1'b0;
    check("t4_pop_push_ovr", bus.rx_overrun_out, 0);
    for (int i = 1; i <= 4; i++) begin
      check("t4_pp_data", bus.rx_data_out, 32 + i);
      rd_pulse();
    end
    check("t4_pp_empty", bus.rx_valid_out, 0);

    // framing error, then false start
    rx_send(8'h55, 1'b0);
    tick(8);
    check("t5_ferr", bus.rx_frame_err_out, 1);
    check("t5_nopush", bus.rx_valid_out, 0);
    check("t5_ovr", bus.rx_overrun_out, 0);
    clr_pulse();
    check("t5_ferr_clr", bus.rx_frame_err_out, 0);
    uart_rxd_in = 1'b0;
    tick(1);
    uart_rxd_in = 1'b1;
    tick(20);
    check("t5_glitch_valid", bus.rx_valid_out, 0);
    check("t5_glitch_ferr", bus.rx_frame_err_out, 0);

`ifdef SERIAL_PARITY_EN
    bus.tx_data_in = 8'h07;
    bus.tx_wren_in = 1'b1;
    tick(1);
    bus.tx_wren_in = 1'b0;
    tx_get(got);
    check("p_tx_byte", got, 8'h07);
    check("p_tx_par", tx_par_seen, 1);
    par_flip = 1'b1;
    rx_send(8'h5A, 1'b1);
    par_flip = 1'b0;
    tick(4);
    check("p_rx_ferr", bus.rx_frame_err_out, 1);
    check("p_rx_nopush", bus.rx_valid_out, 0);
    clr_pulse();
    tick(10);
`endif

    // reset mid-frame
    rx_send(8'h66, 1'b0);
    rx_send(8'h77, 1'b1);
    tick(2);
    check("t6_pre_valid", bus.rx_valid_out, 1);
    check("t6_pre_ferr", bus.rx_frame_err_out, 1);
    bus.tx_data_in = 8'h00;
    bus.tx_wren_in = 1'b1;
    uart_rxd_in = 1'b0;
    tick(2);
    bus.tx_wren_in = 1'b0;
    tick(12);
    check("t6_pre_txd", uart_txd_out, 0);
    reset = 1'b1;
    uart_rxd_in = 1'b1;
    tick(1);
    check("t6_txd", uart_txd_out, 1);
    check("t6_ready", bus.tx_ready_out, 1);
    check("t6_valid", bus.rx_valid_out, 0);
    check("t6_data", bus.rx_data_out, 0);
    check("t6_ferr", bus.rx_frame_err_out, 0);
    check("t6_ovr", bus.rx_overrun_out, 0);
    reset = 1'b0;
    count_lows(60);
    check("t6_tx_idle", lows, 0);
    check("t6_rx_idle", bus.rx_valid_out, 0);
    check("t6_ferr_after", bus.rx_frame_err_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
